// File: rtl/k_and_s_pkg.sv
// Shared types for the K&S processor: instruction decode, opcode values and ALU op encoding.
package k_and_s_pkg;

   typedef enum logic [3:0] {
      I_NOP,
      I_LOAD,
      I_STORE,
      I_MOVE,
      I_ADD,
      I_SUB,
      I_AND,
      I_OR,
      I_BRANCH,
      I_BZERO,
      I_BNEG,
      I_BOV,
      I_HALT
   } decoded_instruction_type;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_OR  = 2'b11
   } alu_op_t;

   localparam logic [7:0] OPC_NOP    = 8'h00;
   localparam logic [7:0] OPC_BRANCH = 8'h01;
   localparam logic [7:0] OPC_BZERO  = 8'h02;
   localparam logic [7:0] OPC_BNEG   = 8'h03;
   localparam logic [7:0] OPC_BOV    = 8'h04;
   localparam logic [7:0] OPC_LOAD   = 8'h81;
   localparam logic [7:0] OPC_STORE  = 8'h82;
   localparam logic [7:0] OPC_MOVE   = 8'h91;
   localparam logic [7:0] OPC_ADD    = 8'hA1;
   localparam logic [7:0] OPC_SUB    = 8'hA2;
   localparam logic [7:0] OPC_AND    = 8'hA3;
   localparam logic [7:0] OPC_OR     = 8'hA4;
   localparam logic [7:0] OPC_HALT   = 8'hFF;

   function automatic decoded_instruction_type decode_opcode(input logic [7:0] opcode);
      decoded_instruction_type d;
      case (opcode)
         OPC_LOAD:   d = I_LOAD;
         OPC_STORE:  d = I_STORE;
         OPC_MOVE:   d = I_MOVE;
         OPC_ADD:    d = I_ADD;
         OPC_SUB:    d = I_SUB;
         OPC_AND:    d = I_AND;
         OPC_OR:     d = I_OR;
         OPC_BRANCH: d = I_BRANCH;
         OPC_BZERO:  d = I_BZERO;
         OPC_BNEG:   d = I_BNEG;
         OPC_BOV:    d = I_BOV;
         OPC_HALT:   d = I_HALT;
         default:    d = I_NOP;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/data_path_alu.sv
// Combinational ALU: ADD/SUB/AND/OR with zero, negative, carry/borrow and signed-overflow flags.
module alu
   import k_and_s_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  alu_op_t           operation,
   output logic [DATA_W-1:0] result,
   output logic              zero,
   output logic              neg,
   output logic              unsigned_ov,
   output logic              signed_ov
);

   logic [DATA_W:0] sum;
   logic [DATA_W:0] diff;

   always_comb begin
      sum         = {1'b0, a} + {1'b0, b};
      diff        = {1'b0, a} - {1'b0, b};
      result      = '0;
      unsigned_ov = 1'b0;
      signed_ov   = 1'b0;
      case (operation)
         ALU_ADD: begin
            result      = sum[DATA_W-1:0];
            unsigned_ov = sum[DATA_W];
            signed_ov   = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
         end
         ALU_SUB: begin
            // The extra top bit of the widened difference is the borrow (a < b unsigned).
            result      = diff[DATA_W-1:0];
            unsigned_ov = diff[DATA_W];
            signed_ov   = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
         end
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         default: result = '0;
      endcase
      zero = (result == '0);
      neg  = result[DATA_W-1];
   end

endmodule

// File: rtl/data_path.sv
// K&S datapath: PC, IR, 4-entry register file, ALU and flags; every update gated by a control-unit enable.
module data_path
   import k_and_s_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 5
) (
   input  logic                    rst_n,
   input  logic                    clk,
   input  logic                    branch,
   input  logic                    pc_enable,
   input  logic                    ir_enable,
   input  logic                    write_reg_enable,
   input  logic                    addr_sel,
   input  logic                    c_sel,
   input  logic [1:0]              operation,
   input  logic                    flags_reg_enable,
   output decoded_instruction_type decoded_instruction,
   output logic                    zero_op,
   output logic                    neg_op,
   output logic                    unsigned_overflow,
   output logic                    signed_overflow,
   output logic [ADDR_W-1:0]       ram_addr,
   output logic [DATA_W-1:0]       data_out,
   input  logic [DATA_W-1:0]       data_in
);

   // IR bit 7 carries no field, so only the opcode byte and bits 6:0 are held.
   logic [7:0]        ir_opcode;
   logic [6:0]        ir_low;
   logic [ADDR_W-1:0] pc;
   logic [DATA_W-1:0] regs [4];

   logic [1:0]        idx_a;
   logic [1:0]        idx_b;
   logic [1:0]        idx_dst;
   logic [1:0]        idx_mem;
   logic [DATA_W-1:0] alu_result;
   logic              alu_zero;
   logic              alu_neg;
   logic              alu_uov;
   logic              alu_sov;
   logic [DATA_W-1:0] wb_value;

   always_comb begin
      decoded_instruction = decode_opcode(ir_opcode);
      idx_mem             = ir_low[6:5];
      idx_a               = ir_low[3:2];
      idx_b               = (decoded_instruction == I_MOVE) ? ir_low[3:2] : ir_low[1:0];
      idx_dst             = (decoded_instruction == I_LOAD) ? ir_low[6:5] : ir_low[5:4];
      wb_value            = c_sel ? data_in : alu_result;
      ram_addr            = addr_sel ? ir_low[ADDR_W-1:0] : pc;
      data_out            = regs[idx_mem];
   end

   alu #(.DATA_W(DATA_W)) u_alu (
      .a           (regs[idx_a]),
      .b           (regs[idx_b]),
      .operation   (alu_op_t'(operation)),
      .result      (alu_result),
      .zero        (alu_zero),
      .neg         (alu_neg),
      .unsigned_ov (alu_uov),
      .signed_ov   (alu_sov)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc        <= '0;
         ir_opcode <= '0;
         ir_low    <= '0;
      end else begin
         if (pc_enable)
            pc <= branch ? ir_low[ADDR_W-1:0] : pc + ADDR_W'(1);
         if (ir_enable) begin
            ir_opcode <= data_in[DATA_W-1:DATA_W-8];
            ir_low    <= data_in[6:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 4; i++)
            regs[i] <= '0;
      end else if (write_reg_enable) begin
         regs[idx_dst] <= wb_value;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero_op           <= 1'b0;
         neg_op            <= 1'b0;
         unsigned_overflow <= 1'b0;
         signed_overflow   <= 1'b0;
      end else if (flags_reg_enable) begin
         zero_op           <= alu_zero;
         neg_op            <= alu_neg;
         unsigned_overflow <= alu_uov;
         signed_overflow   <= alu_sov;
      end
   end

endmodule
